// File: rtl/opcol_pkg.sv
// Shared types and helpers for the operand collector.
package opcol_pkg;

   typedef enum logic {COLLECT = 1'b0, WAIT_DS = 1'b1} state_e;

   // Beat-counter width: never narrower than one bit, even for a single beat.
   function automatic int cnt_w(input int total);
      return (total <= 2) ? 1 : $clog2(total);
   endfunction

endpackage

// File: rtl/operand_collector_if.sv
// Beat bus, downstream launch and status signals of the operand collector.
interface operand_collector_if import opcol_pkg::*; #(
   parameter int BUS_W   = 8,
   parameter int OP_W    = 16,
   parameter int NUM_OPS = 2
);
   localparam int CNT_W = cnt_w(NUM_OPS * (OP_W / BUS_W));

   logic                      clear;
   logic                      in_valid;
   logic [BUS_W-1:0]          in_data;
   logic                      in_ready;
   logic                      ds_ready;
   logic                      start;
   logic [NUM_OPS*OP_W-1:0]   ops_out;
   logic                      busy;
   logic [CNT_W-1:0]          beat_idx;
   logic                      zero_err;

   modport master (output clear, in_valid, in_data, ds_ready,
                   input  in_ready, start, ops_out, busy, beat_idx, zero_err);
   modport slave  (input  clear, in_valid, in_data, ds_ready,
                   output in_ready, start, ops_out, busy, beat_idx, zero_err);
endinterface

// File: rtl/opcol_beat_counter.sv
// Modulo-MAX beat counter; clr wins over en, wraps to 0 after the last beat.
module opcol_beat_counter #(
   parameter int MAX = 4,
   parameter int W   = 2
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         clr,
   input  logic         en,
   output logic [W-1:0] cnt,
   output logic         last
);
   logic [W-1:0] cnt_q, cnt_d;

   assign last = (cnt_q == W'(MAX - 1));
   assign cnt  = cnt_q;

   always_comb begin
      cnt_d = cnt_q;
      if (clr)     cnt_d = '0;
      else if (en) cnt_d = last ? '0 : cnt_q + W'(1);
   end

   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) cnt_q <= '0;
      else          cnt_q <= cnt_d;

endmodule

// File: rtl/operand_collector.sv
// Collects NUM_OPS operands MSB beat first, then launches them with a start pulse.
// Optional divisor-zero rejection is compiled in with OPCOL_ZERO_CHECK_EN.
module operand_collector import opcol_pkg::*; #(
   parameter int BUS_W   = 8,
   parameter int OP_W    = 16,
   parameter int NUM_OPS = 2
) (
   input logic                 clk,
   input logic                 reset_n,
   operand_collector_if.slave  bus
);
   localparam int BPO   = OP_W / BUS_W;
   localparam int TOTAL = NUM_OPS * BPO;
   localparam int CNT_W = cnt_w(TOTAL);

   state_e                         state_q, state_d;
   logic [TOTAL-1:0][BUS_W-1:0]    stage_q, stage_d;
   logic [NUM_OPS*OP_W-1:0]        ops_q, ops_d;
   logic                           start_q, start_d;
   logic [CNT_W-1:0]               cnt, widx;
   logic                           last, in_ready, accept, launch, div_zero;

   opcol_beat_counter #(.MAX(TOTAL), .W(CNT_W)) u_cnt (
      .clk(clk), .reset_n(reset_n), .clr(bus.clear), .en(accept),
      .cnt(cnt), .last(last)
   );

   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) state_q <= COLLECT;
      else          state_q <= state_d;

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         COLLECT: if (accept && last) state_d = WAIT_DS;
         WAIT_DS: if (bus.clear || div_zero || bus.ds_ready) state_d = COLLECT;
         default: state_d = COLLECT;
      endcase
   end

   always_comb begin
      in_ready = (state_q == COLLECT);
      accept   = in_ready && bus.in_valid && !bus.clear;
      launch   = (state_q == WAIT_DS) && !bus.clear && bus.ds_ready && !div_zero;
   end

   // Beat k lands in word (k/BPO)*BPO + BPO-1-(k%BPO): first beat of an operand is its MSB.
   always_comb begin
      widx    = CNT_W'((int'(cnt) / BPO) * BPO + (BPO - 1) - (int'(cnt) % BPO));
      stage_d = stage_q;
      ops_d   = ops_q;
      start_d = launch;
      if (accept) stage_d[widx] = bus.in_data;
      if (launch) ops_d = stage_q;
   end

   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         stage_q <= '0;
         ops_q   <= '0;
         start_q <= 1'b0;
      end else begin
         stage_q <= stage_d;
         ops_q   <= ops_d;
         start_q <= start_d;
      end

`ifdef OPCOL_ZERO_CHECK_EN
   logic zerr_q;
   assign div_zero = (stage_q[TOTAL-1 -: BPO] == '0);
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) zerr_q <= 1'b0;
      else          zerr_q <= (state_q == WAIT_DS) && !bus.clear && div_zero;
   assign bus.zero_err = zerr_q;
`else
   assign div_zero     = 1'b0;
   assign bus.zero_err = 1'b0;
`endif

   assign bus.in_ready = in_ready;
   assign bus.start    = start_q;
   assign bus.ops_out  = ops_q;
   assign bus.busy     = (state_q == WAIT_DS) || (cnt != '0);
   assign bus.beat_idx = cnt;

endmodule

// File: tb/tb_operand_collector.sv
// Self-checking bench for operand_collector: directed scenarios plus a randomized
// run against a queue-based model. Zero-check expectations follow OPCOL_ZERO_CHECK_EN.
module tb_operand_collector;
   typedef logic [7:0] bq_t[$];

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   operand_collector_if #(.BUS_W(8), .OP_W(16), .NUM_OPS(2)) if0();
   operand_collector_if #(.BUS_W(8), .OP_W(32), .NUM_OPS(3)) if1();

   operand_collector #(.BUS_W(8), .OP_W(16), .NUM_OPS(2)) dut0 (
      .clk(clk), .reset_n(reset_n), .bus(if0.slave));
   operand_collector #(.BUS_W(8), .OP_W(32), .NUM_OPS(3)) dut1 (
      .clk(clk), .reset_n(reset_n), .bus(if1.slave));

   int checks = 0;
   int failures = 0;
   logic [31:0] exp_out0 = '0;   // last set launched by dut0

   // Operand i is the big-endian concatenation of beats i*bpo .. i*bpo+bpo-1.
   function automatic logic [95:0] assemble(input bq_t b, input int bpo, input int nops);
      logic [95:0] r = '0;
      for (int i = nops - 1; i >= 0; i--)
         for (int j = 0; j < bpo; j++) r = (r << 8) | 96'(b[i*bpo+j]);
      return r;
   endfunction

   task automatic cyc();
      @(posedge clk); #1;
   endtask

   task automatic send0(input logic [7:0] d);
      if0.in_valid = 1'b1; if0.in_data = d;
      cyc();
      if0.in_valid = 1'b0;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      cyc(); cyc();
      checks++;
      if ({if0.in_ready, if0.start, if0.busy, if0.beat_idx, if0.zero_err} !== 6'b100000) begin
         failures++;
         $display("FAIL reset_status0 got=%b exp=100000",
                  {if0.in_ready, if0.start, if0.busy, if0.beat_idx, if0.zero_err});
      end
      checks++;
      if (if0.ops_out !== 32'h0) begin
         failures++; $display("FAIL reset_ops0 got=%h exp=0", if0.ops_out);
      end
      checks++;
      if ({if1.in_ready, if1.start, if1.busy, if1.beat_idx} !== 7'b1000000 || if1.ops_out !== 96'h0) begin
         failures++;
         $display("FAIL reset_dut1 got=%b/%h exp=1000000/0",
                  {if1.in_ready, if1.start, if1.busy, if1.beat_idx}, if1.ops_out);
      end
      reset_n = 1'b1;
      cyc();
   endtask

   task automatic test_basic();
      logic [7:0] b[4] = '{8'h12, 8'h34, 8'h56, 8'h78};
      if0.ds_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         send0(b[k]);
         checks++;
         if (k < 3 && {if0.beat_idx, if0.busy, if0.in_ready} !== {2'(k + 1), 2'b11}) begin
            failures++;
            $display("FAIL basic_idx%0d got=%b exp=%b", k,
                     {if0.beat_idx, if0.busy, if0.in_ready}, {2'(k + 1), 2'b11});
         end else if (k == 3 && {if0.beat_idx, if0.busy, if0.in_ready, if0.start} !== 5'b00100) begin
            failures++;
            $display("FAIL basic_wait got=%b exp=00100",
                     {if0.beat_idx, if0.busy, if0.in_ready, if0.start});
         end
      end
      cyc();
      checks++;
      if ({if0.start, if0.busy, if0.in_ready} !== 3'b101 || if0.ops_out !== 32'h5678_1234) begin
         failures++;
         $display("FAIL basic_launch got=%b/%h exp=101/56781234",
                  {if0.start, if0.busy, if0.in_ready}, if0.ops_out);
      end
      exp_out0 = 32'h5678_1234;
      cyc();
      checks++;
      if (if0.start !== 1'b0) begin
         failures++; $display("FAIL basic_pulse got=%b exp=0", if0.start);
      end
   endtask

   task automatic test_stall();
      bq_t q;
      logic [31:0] exp;
      if0.ds_ready = 1'b0;
      for (int k = 0; k < 4; k++) begin
         q.push_back(8'($urandom));
         send0(q[k]);
      end
      exp = assemble(q, 2, 2)[31:0];
      for (int c = 0; c < 5; c++) begin
         if0.in_valid = 1'b1; if0.in_data = 8'($urandom);
         cyc();
         checks++;
         if ({if0.in_ready, if0.start, if0.busy} !== 3'b001 || if0.ops_out !== exp_out0) begin
            failures++;
            $display("FAIL stall_c%0d got=%b/%h exp=001/%h", c,
                     {if0.in_ready, if0.start, if0.busy}, if0.ops_out, exp_out0);
         end
      end
      if0.in_valid = 1'b0; if0.ds_ready = 1'b1;
      cyc();
      checks++;
      if (if0.start !== 1'b1 || if0.ops_out !== exp) begin
         failures++; $display("FAIL stall_launch got=%b/%h exp=1/%h", if0.start, if0.ops_out, exp);
      end
      exp_out0 = exp;
      cyc();
   endtask

   task automatic test_gaps();
      logic       v[7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
      logic [7:0] b[4] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
      int n = 0;
      if0.ds_ready = 1'b1;
      for (int i = 0; i < 7; i++) begin
         if0.in_valid = v[i];
         if0.in_data  = v[i] ? b[n] : 8'hEE;
         cyc();
         if (v[i]) n++;
         checks++;
         if (if0.beat_idx !== 2'(n % 4) || if0.in_ready !== (n < 4)) begin
            failures++;
            $display("FAIL gaps_c%0d got=%0d/%b exp=%0d/%b", i, if0.beat_idx, if0.in_ready, n % 4, n < 4);
         end
      end
      if0.in_valid = 1'b0;
      cyc();
      checks++;
      if (if0.start !== 1'b1 || if0.ops_out !== 32'hCCDD_AABB) begin
         failures++; $display("FAIL gaps_launch got=%b/%h exp=1/ccddaabb", if0.start, if0.ops_out);
      end
      exp_out0 = 32'hCCDD_AABB;
      cyc();
   endtask

   task automatic test_clear();
      if0.ds_ready = 1'b1;
      send0(8'h77); send0(8'h66);
      if0.clear = 1'b1; if0.in_valid = 1'b1; if0.in_data = 8'h55;
      cyc();
      if0.clear = 1'b0; if0.in_valid = 1'b0;
      checks++;
      if ({if0.beat_idx, if0.busy} !== 3'b000 || if0.ops_out !== exp_out0) begin
         failures++;
         $display("FAIL clear_collect got=%b/%h exp=000/%h", {if0.beat_idx, if0.busy}, if0.ops_out, exp_out0);
      end
      for (int k = 1; k <= 4; k++) send0(8'(k));
      checks++;
      if (if0.ops_out !== exp_out0) begin
         failures++; $display("FAIL clear_hold got=%h exp=%h", if0.ops_out, exp_out0);
      end
      cyc();
      checks++;
      if (if0.start !== 1'b1 || if0.ops_out !== 32'h0304_0102) begin
         failures++; $display("FAIL clear_fresh got=%b/%h exp=1/03040102", if0.start, if0.ops_out);
      end
      exp_out0 = 32'h0304_0102;
      // clear in WAIT_DS outranks a simultaneous ds_ready
      if0.ds_ready = 1'b0;
      for (int k = 0; k < 4; k++) send0(8'hF0 + 8'(k));
      if0.ds_ready = 1'b1; if0.clear = 1'b1;
      cyc();
      if0.clear = 1'b0;
      checks++;
      if ({if0.start, if0.in_ready, if0.busy} !== 3'b010 || if0.ops_out !== exp_out0) begin
         failures++;
         $display("FAIL clear_wait got=%b/%h exp=010/%h", {if0.start, if0.in_ready, if0.busy}, if0.ops_out, exp_out0);
      end
      cyc();
      checks++;
      if (if0.start !== 1'b0) begin
         failures++; $display("FAIL clear_nolaunch got=%b exp=0", if0.start);
      end
      // clear outranks acceptance of the final beat
      for (int k = 0; k < 3; k++) send0(8'h11);
      if0.clear = 1'b1; if0.in_valid = 1'b1; if0.in_data = 8'h22;
      cyc();
      if0.clear = 1'b0; if0.in_valid = 1'b0;
      checks++;
      if ({if0.beat_idx, if0.in_ready, if0.busy} !== 4'b0010) begin
         failures++; $display("FAIL clear_last got=%b exp=0010", {if0.beat_idx, if0.in_ready, if0.busy});
      end
   endtask

   task automatic test_reset_mid();
      bq_t q;
      logic [31:0] exp;
      if0.ds_ready = 1'b1;
      for (int k = 0; k < 3; k++) send0(8'h3C);
      checks++;
      if (if0.beat_idx !== 2'd3) begin
         failures++; $display("FAIL rstmid_idx got=%0d exp=3", if0.beat_idx);
      end
      #2 reset_n = 1'b0;
      #1;
      checks++;
      if ({if0.start, if0.busy, if0.beat_idx, if0.zero_err, if0.in_ready} !== 6'b000001 || if0.ops_out !== 32'h0) begin
         failures++;
         $display("FAIL rstmid_async got=%b/%h exp=000001/0",
                  {if0.start, if0.busy, if0.beat_idx, if0.zero_err, if0.in_ready}, if0.ops_out);
      end
      exp_out0 = '0;
      cyc();
      reset_n = 1'b1;
      for (int k = 0; k < 4; k++) begin
         q.push_back(8'($urandom));
         send0(q[k]);
      end
      exp = assemble(q, 2, 2)[31:0];
      cyc();
      checks++;
      if (if0.start !== 1'b1 || if0.ops_out !== exp) begin
         failures++; $display("FAIL rstmid_clean got=%b/%h exp=1/%h", if0.start, if0.ops_out, exp);
      end
      exp_out0 = exp;
      cyc();
   endtask

   task automatic test_zero();
      logic [7:0] b[4] = '{8'h00, 8'h09, 8'h00, 8'h00};
`ifdef OPCOL_ZERO_CHECK_EN
      if0.ds_ready = 1'b0;
      for (int k = 0; k < 4; k++) send0(b[k]);
      cyc();
      checks++;
      if ({if0.zero_err, if0.start, if0.in_ready, if0.busy} !== 4'b1010 || if0.ops_out !== exp_out0) begin
         failures++;
         $display("FAIL zero_reject got=%b/%h exp=1010/%h",
                  {if0.zero_err, if0.start, if0.in_ready, if0.busy}, if0.ops_out, exp_out0);
      end
      cyc();
      checks++;
      if ({if0.zero_err, if0.start} !== 2'b00) begin
         failures++; $display("FAIL zero_pulse got=%b exp=00", {if0.zero_err, if0.start});
      end
`else
      if0.ds_ready = 1'b1;
      for (int k = 0; k < 4; k++) send0(b[k]);
      cyc();
      checks++;
      if ({if0.zero_err, if0.start} !== 2'b01 || if0.ops_out !== 32'h0000_0009) begin
         failures++;
         $display("FAIL zero_nocheck got=%b/%h exp=01/00000009", {if0.zero_err, if0.start}, if0.ops_out);
      end
      exp_out0 = 32'h0000_0009;
      cyc();
`endif
   endtask

   task automatic test_wide();
      bq_t q;
      logic [95:0] exp;
      if1.ds_ready = 1'b1;
      for (int k = 0; k < 12; k++) begin
         q.push_back(8'($urandom) | ((k == 8) ? 8'h01 : 8'h00));
         if1.in_valid = 1'b1; if1.in_data = q[k];
         cyc();
      end
      if1.in_valid = 1'b0;
      exp = assemble(q, 4, 3);
      cyc();
      checks++;
      if (if1.start !== 1'b1 || if1.ops_out !== exp) begin
         failures++; $display("FAIL wide_launch got=%b/%h exp=1/%h", if1.start, if1.ops_out, exp);
      end
      cyc();
   endtask

   task automatic test_back_to_back();
      bq_t q;
      logic [31:0] pend = '0;
      logic waiting = 1'b0;
      logic v, ds, cl, zero, exp_start, exp_z;
      logic [7:0] d;
      for (int c = 0; c < 400; c++) begin
         v  = ($urandom % 4) != 0;
         ds = ($urandom % 3) != 0;
         cl = ($urandom % 20) == 0;
         d  = (($urandom % 4) == 0) ? 8'h00 : 8'($urandom);
         if0.in_valid = v; if0.in_data = d; if0.ds_ready = ds; if0.clear = cl;
         cyc();
         exp_start = 1'b0; exp_z = 1'b0;
         if (cl) begin
            q.delete(); waiting = 1'b0;
         end else if (!waiting) begin
            if (v) begin
               q.push_back(d);
               if (q.size() == 4) begin
                  pend = assemble(q, 2, 2)[31:0]; q.delete(); waiting = 1'b1;
               end
            end
         end else begin
            zero = 1'b0;
`ifdef OPCOL_ZERO_CHECK_EN
            zero = (pend[31:16] == 16'h0);
`endif
            if (zero) begin
               exp_z = 1'b1; waiting = 1'b0;
            end else if (ds) begin
               exp_start = 1'b1; exp_out0 = pend; waiting = 1'b0;
            end
         end
         checks++;
         if ({if0.start, if0.zero_err, if0.in_ready, if0.busy, if0.beat_idx} !==
             {exp_start, exp_z, !waiting, waiting || q.size() != 0, 2'(q.size())}) begin
            failures++;
            $display("FAIL rand_ctl_c%0d got=%b exp=%b", c,
                     {if0.start, if0.zero_err, if0.in_ready, if0.busy, if0.beat_idx},
                     {exp_start, exp_z, !waiting, waiting || q.size() != 0, 2'(q.size())});
         end
         checks++;
         if (if0.ops_out !== exp_out0) begin
            failures++; $display("FAIL rand_ops_c%0d got=%h exp=%h", c, if0.ops_out, exp_out0);
         end
      end
      if0.in_valid = 1'b0; if0.clear = 1'b0;
   endtask

   initial begin
      if0.clear = 1'b0; if0.in_valid = 1'b0; if0.in_data = '0; if0.ds_ready = 1'b0;
      if1.clear = 1'b0; if1.in_valid = 1'b0; if1.in_data = '0; if1.ds_ready = 1'b0;
      test_reset();
      test_basic();
      test_stall();
      test_gaps();
      test_clear();
      test_reset_mid();
      test_zero();
      test_wide();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/operand_collector.md
Name: operand_collector

Overview:
Parametrised successor to the divider's byte-serial input wrapper. It accepts NUM_OPS operands of OP_W bits over a BUS_W-bit valid/ready input bus, most-significant beat first, into a staging buffer. It then launches them to a downstream compute block (divider or similar) with a one-cycle start pulse once that block signals ready. Output operands are double-buffered, so the next operand set can be collected while the current one is being consumed.

Parameters:
BUS_W, 8, input bus width in bits
OP_W, 16, operand width; must be an integer multiple of BUS_W
NUM_OPS, 2, operands per transaction; must be >= 1
(derived) BEATS_PER_OP = OP_W/BUS_W; TOTAL_BEATS = NUM_OPS*BEATS_PER_OP; CNT_W = max(1, $clog2(TOTAL_BEATS))

Ports:
clk  in  1  rising-edge clock
reset_n  in  1  asynchronous, active-low reset
clear  in  1  synchronous flush of an in-progress collection
in_valid  in  1  source has a beat on in_data
in_data  in  BUS_W  beat payload
in_ready  out  1  collector accepts a beat this cycle
ds_ready  in  1  downstream can take a new operand set
start  out  1  one-cycle pulse; ops_out holds a new set
ops_out  out  NUM_OPS*OP_W  operand i at [i*OP_W +: OP_W]
busy  out  1  staging partially or fully filled
beat_idx  out  CNT_W  index of the next beat to be accepted
zero_err  out  1  one-cycle pulse: last operand zero (see Optional Feature)

Behaviour:
- Reset (reset_n=0, asynchronous): state=COLLECT, beat counter=0, staging=0, ops_out=0, start=0, zero_err=0, busy=0, beat_idx=0. in_ready is combinational and equals 1 after reset.
- States: COLLECT and WAIT_DS.
- COLLECT:
  - in_ready=1.
  - A beat is accepted on a rising edge with in_valid && in_ready.
  - Beat k is written to operand k/BEATS_PER_OP, slice (BEATS_PER_OP-1-k%BEATS_PER_OP)*BUS_W, i.e. MSB beat first.
  - The counter increments on each accepted beat.
  - When the beat with k=TOTAL_BEATS-1 is accepted: counter returns to 0 and next state is WAIT_DS.
- WAIT_DS:
  - in_ready=0; in_data is ignored.
  - On the first edge with ds_ready=1: ops_out <= staging, start <= 1 for exactly one cycle, next state is COLLECT.
  - Minimum latency is one cycle: start is high in the cycle after the edge that accepted the last beat, provided ds_ready=1.
- start and ops_out are registered. ops_out stays stable from launch until the next launch, independent of new collection.
- busy = (state==WAIT_DS) || (beat counter != 0).
- clear:
  - In COLLECT: counter <= 0 and the partial set is discarded; staging contents are don't-care.
  - In WAIT_DS: return to COLLECT without launching.
  - clear takes priority over a simultaneous beat acceptance or launch. ops_out is never affected by clear.
- in_valid without in_ready: no state change; the source must hold in_data until accepted.
- Mid-operation reset: everything returns to reset values immediately; there is no partial launch.
- TOTAL_BEATS==1: every accepted beat moves the block to WAIT_DS.

Optional Feature:
OPCOL_ZERO_CHECK_EN.
- Defined: in WAIT_DS, if staging operand NUM_OPS-1 == 0 (the divisor, for the divider), the launch edge does the following instead of a normal launch:
  - zero_err <= 1 for one cycle;
  - start stays 0;
  - ops_out is not updated;
  - next state is COLLECT.
  This happens on the first edge in WAIT_DS, regardless of ds_ready.
- Undefined: no check is performed and zero_err is tied to 0. The port always exists.

Decomposition:
- opcol_pkg: state enum type (COLLECT, WAIT_DS), plus a function computing CNT_W from TOTAL_BEATS.
- Sub-module opcol_beat_counter: parameters MAX and W; inputs clk, reset_n, clr, en; outputs cnt and last (cnt==MAX-1). It wraps to 0 on en && last.
- The top level holds the FSM, the staging array, the output registers and the zero check.

Test Plan:
1. Defaults, ds_ready=1, beats 0x12,0x34,0x56,0x78 on consecutive cycles -> start high one cycle after the 4th acceptance; operand0=0x1234, operand1=0x5678; busy low after start.
2. ds_ready=0 held 5 cycles after the last beat -> in_ready=0 throughout and ops_out unchanged; start pulses the cycle after ds_ready rises.
3. in_valid gaps (1,0,0,1,1,0,1) with beats 0xAA,0xBB,0xCC,0xDD -> only valid cycles are counted; beat_idx steps 0->1->2->3; operands 0xAABB and 0xCCDD.
4. clear after 2 beats, then 4 fresh beats 0x01,0x02,0x03,0x04 -> operands 0x0102 and 0x0304; the first launch's ops_out is preserved until this one.
5. reset_n low mid-collection (beat_idx=3) -> all outputs 0 immediately; the next 4 beats produce a clean set.
6. OPCOL_ZERO_CHECK_EN defined, beats 0x00,0x09,0x00,0x00 -> zero_err pulses once, no start, ops_out retains its prior value. Separately, with BUS_W=8, OP_W=32, NUM_OPS=3, 12 beats are assembled correctly MSB-first.
